// File: rtl/eth_link_pkg.sv
// eth_link_pkg: shared state encodings, parameter defaults and
// counter-width helper for the 10G link supervisor.
package eth_link_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_GT    = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_UP         = 3'd2,
      ST_RESET_RX   = 3'd3,
      ST_RESET_ALL  = 3'd4
   } link_state_e;

   // 10 ms at 156.25 MHz
   localparam int unsigned DEF_LOCK_TIMEOUT = 1562500;
   localparam int unsigned DEF_DEBOUNCE     = 1024;
   localparam int unsigned DEF_RESET_PULSE  = 16;
   localparam int unsigned DEF_MAX_RETRIES  = 4;

   function automatic int unsigned cnt_width(
      input int unsigned lock_timeout
   );
      return $clog2(lock_timeout + 1);
   endfunction

endpackage

// File: rtl/sync_signal.sv
// sync_signal: N-stage flip-flop synchronizer for asynchronous levels.
// Ports: clk, rst (async high), data_in (async), data_out (clk domain).
module sync_signal #(
   parameter int WIDTH = 1,
   parameter int N     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] sync_reg [N];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            sync_reg[i] <= '0;
         end
      end else begin
         sync_reg[0] <= data_in;
         for (int i = 1; i < N; i++) begin
            sync_reg[i] <= sync_reg[i-1];
         end
      end
   end

   assign data_out = sync_reg[N-1];

endmodule

// File: rtl/eth_link_supervisor.sv
// eth_link_supervisor: per-port 10G link bring-up and recovery FSM.
// Ports: clk/rst; async GT done, block lock, high BER inputs;
// registered GT reset pulses; link_up/link_state; retry and
// link-down counters.
module eth_link_supervisor
   import eth_link_pkg::*;
#(
   parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int unsigned DEBOUNCE     = DEF_DEBOUNCE,
   parameter int unsigned RESET_PULSE  = DEF_RESET_PULSE,
   parameter int unsigned MAX_RETRIES  = DEF_MAX_RETRIES
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gt_reset_tx_done,
   input  logic        gt_reset_rx_done,
   input  logic        rx_block_lock,
   input  logic        rx_high_ber,
   output logic        gt_reset_rx_datapath,
   output logic        gt_reset_all,
   output logic        link_up,
   output logic [2:0]  link_state,
   output logic [7:0]  retry_count,
   output logic [15:0] link_down_events
);

   localparam int unsigned CNT_W = cnt_width(LOCK_TIMEOUT);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t TMO_LAST   = cnt_t'(LOCK_TIMEOUT - 1);
   localparam cnt_t DEB_LAST   = cnt_t'(DEBOUNCE - 1);
   localparam cnt_t PULSE_LAST = cnt_t'(RESET_PULSE - 1);
   localparam cnt_t CNT_MAX    = '1;
   localparam logic [7:0] MAX_R8 = 8'(MAX_RETRIES);

   if (MAX_RETRIES > 255) begin : g_bad_retries
      $error("MAX_RETRIES must be <= 255");
   end
   if (DEBOUNCE > LOCK_TIMEOUT || DEBOUNCE == 0) begin : g_bad_deb
      $error("DEBOUNCE must be 1..LOCK_TIMEOUT");
   end
   if (RESET_PULSE > LOCK_TIMEOUT || RESET_PULSE == 0)
   begin : g_bad_pulse
      $error("RESET_PULSE must be 1..LOCK_TIMEOUT");
   end

   logic [3:0] async_vec;
   logic [3:0] sync_vec;

   assign async_vec = {rx_high_ber, rx_block_lock,
                       gt_reset_rx_done, gt_reset_tx_done};

   sync_signal #(
      .WIDTH (4),
      .N     (2)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .data_in  (async_vec),
      .data_out (sync_vec)
   );

   logic gt_ok;
   logic good;

   assign gt_ok = sync_vec[0] & sync_vec[1];
   assign good  = sync_vec[2] & ~sync_vec[3];

   link_state_e state;
   link_state_e state_nxt;
   cnt_t        timer;
   cnt_t        deb;
   logic [7:0]  retry_nxt;
   logic        down_evt;
   logic        deb_cond;
   logic        state_chg;

   // One debounce counter serves both directions: it counts
   // good cycles while waiting for lock and bad cycles while up.
   always_comb begin
      deb_cond = 1'b0;
      unique case (1'b1)
         state == ST_WAIT_LOCK: deb_cond = good;
         state == ST_UP:        deb_cond = ~good;
         default:               deb_cond = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_count;
      down_evt  = 1'b0;
      case (state)
         ST_WAIT_GT: begin
            if (gt_ok) begin
               state_nxt = ST_WAIT_LOCK;
            end else if (timer == TMO_LAST) begin
               state_nxt = ST_RESET_ALL;
               retry_nxt = '0;
            end
         end
         ST_WAIT_LOCK: begin
            if (!gt_ok) begin
               state_nxt = ST_WAIT_GT;
            end else if (good && deb == DEB_LAST) begin
               state_nxt = ST_UP;
            end else if (timer == TMO_LAST) begin
               if (retry_count < MAX_R8) begin
                  state_nxt = ST_RESET_RX;
                  retry_nxt = retry_count + 8'd1;
               end else begin
                  state_nxt = ST_RESET_ALL;
                  retry_nxt = '0;
               end
            end
         end
         ST_UP: begin
            if (!gt_ok) begin
               state_nxt = ST_WAIT_GT;
               down_evt  = 1'b1;
            end else if (!good && deb == DEB_LAST) begin
               state_nxt = ST_RESET_RX;
               down_evt  = 1'b1;
            end
         end
         ST_RESET_RX, ST_RESET_ALL: begin
            if (timer == PULSE_LAST) begin
               state_nxt = ST_WAIT_GT;
            end
         end
         default: state_nxt = ST_WAIT_GT;
      endcase
      if (state_nxt == ST_UP && state != ST_UP) begin
         retry_nxt = '0;
      end
   end

   assign state_chg = (state_nxt != state);

   // Outputs are decoded from the next state so they change on
   // the same edge as link_state and never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= ST_WAIT_GT;
         timer                <= '0;
         deb                  <= '0;
         retry_count          <= '0;
         link_down_events     <= '0;
         link_up              <= 1'b0;
         gt_reset_rx_datapath <= 1'b0;
         gt_reset_all         <= 1'b0;
      end else begin
         state       <= state_nxt;
         retry_count <= retry_nxt;
         if (state_chg) begin
            timer <= '0;
         end else if (timer != CNT_MAX) begin
            timer <= timer + 1'b1;
         end
         if (state_chg || !deb_cond) begin
            deb <= '0;
         end else if (deb != CNT_MAX) begin
            deb <= deb + 1'b1;
         end
         if (down_evt && link_down_events != 16'hFFFF) begin
            link_down_events <= link_down_events + 16'd1;
         end
         link_up              <= (state_nxt == ST_UP);
         gt_reset_rx_datapath <= (state_nxt == ST_RESET_RX);
         gt_reset_all         <= (state_nxt == ST_RESET_ALL);
      end
   end

   assign link_state = state;

endmodule

// File: tb/tb_eth_link_supervisor.sv
// tb_eth_link_supervisor: directed self-checking bench for
// eth_link_supervisor with short timeouts.
module tb_eth_link_supervisor;

   localparam int unsigned LT  = 200;
   localparam int unsigned DB  = 8;
   localparam int unsigned RP  = 4;
   localparam int unsigned MR  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        gt_reset_tx_done;
   logic        gt_reset_rx_done;
   logic        rx_block_lock;
   logic        rx_high_ber;
   logic        gt_reset_rx_datapath;
   logic        gt_reset_all;
   logic        link_up;
   logic [2:0]  link_state;
   logic [7:0]  retry_count;
   logic [15:0] link_down_events;

   int checks;
   int failures;
   int rx_hi;
   int all_hi;
   int both_hi;
   int r0;
   int a0;
   logic stayed;

   eth_link_supervisor #(
      .LOCK_TIMEOUT (LT),
      .DEBOUNCE     (DB),
      .RESET_PULSE  (RP),
      .MAX_RETRIES  (MR)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .gt_reset_tx_done     (gt_reset_tx_done),
      .gt_reset_rx_done     (gt_reset_rx_done),
      .rx_block_lock        (rx_block_lock),
      .rx_high_ber          (rx_high_ber),
      .gt_reset_rx_datapath (gt_reset_rx_datapath),
      .gt_reset_all         (gt_reset_all),
      .link_up              (link_up),
      .link_state           (link_state),
      .retry_count          (retry_count),
      .link_down_events     (link_down_events)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (gt_reset_rx_datapath) rx_hi <= rx_hi + 1;
      if (gt_reset_all) all_hi <= all_hi + 1;
      if (gt_reset_rx_datapath && gt_reset_all)
         both_hi <= both_hi + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic wait_up(input int budget, input string tag);
      int n = 0;
      while (!link_up && n < budget) begin
         step(1);
         n++;
      end
      chk(tag, 32'(link_up), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_state"}, 32'(link_state), 32'd0);
      chk({tag, "_up"}, 32'(link_up), 32'd0);
      chk({tag, "_rxp"}, 32'(gt_reset_rx_datapath), 32'd0);
      chk({tag, "_allp"}, 32'(gt_reset_all), 32'd0);
      chk({tag, "_retry"}, 32'(retry_count), 32'd0);
      chk({tag, "_down"}, 32'(link_down_events), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b1;
      gt_reset_tx_done = 1'b1;
      gt_reset_rx_done = 1'b1;
      rx_block_lock    = 1'b1;
      rx_high_ber      = 1'b0;
      step(3);
      chk_idle("rst");

      // 1: bring-up with everything good
      rst = 1'b0;
      r0 = rx_hi;
      a0 = all_hi;
      step(2);
      chk("t1_c2_state", 32'(link_state), 32'd0);
      step(1);
      chk("t1_c3_state", 32'(link_state), 32'd1);
      step(7);
      chk("t1_c10_up", 32'(link_up), 32'd0);
      step(1);
      chk("t1_c11_up", 32'(link_up), 32'd1);
      chk("t1_c11_state", 32'(link_state), 32'd2);
      chk("t1_rxp", 32'(rx_hi - r0), 32'd0);
      chk("t1_allp", 32'(all_hi - a0), 32'd0);

      // 2: short lock dropout is filtered
      rx_block_lock = 1'b0;
      step(5);
      rx_block_lock = 1'b1;
      stayed = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step(1);
         stayed = stayed & link_up;
      end
      chk("t2_stayed", 32'(stayed), 32'd1);
      chk("t2_down", 32'(link_down_events), 32'd0);

      // 3: long dropout triggers RX datapath reset
      r0 = rx_hi;
      rx_block_lock = 1'b0;
      step(9);
      chk("t3_c9_up", 32'(link_up), 32'd1);
      step(1);
      chk("t3_c10_up", 32'(link_up), 32'd0);
      chk("t3_c10_state", 32'(link_state), 32'd3);
      chk("t3_c10_rxp", 32'(gt_reset_rx_datapath), 32'd1);
      chk("t3_down", 32'(link_down_events), 32'd1);
      step(3);
      chk("t3_c13_state", 32'(link_state), 32'd3);
      step(1);
      chk("t3_c14_state", 32'(link_state), 32'd0);
      chk("t3_rxp_len", 32'(rx_hi - r0), 32'd4);
      step(6);
      rx_block_lock = 1'b1;
      wait_up(40, "t3_relock");
      chk("t3_retry", 32'(retry_count), 32'd0);

      // 5: one-cycle rx_done glitch
      r0 = rx_hi;
      a0 = all_hi;
      gt_reset_rx_done = 1'b0;
      step(1);
      gt_reset_rx_done = 1'b1;
      step(1);
      chk("t5_c2_state", 32'(link_state), 32'd2);
      step(1);
      chk("t5_c3_state", 32'(link_state), 32'd0);
      chk("t5_c3_up", 32'(link_up), 32'd0);
      chk("t5_down", 32'(link_down_events), 32'd2);
      step(1);
      chk("t5_c4_state", 32'(link_state), 32'd1);
      step(7);
      chk("t5_c11_up", 32'(link_up), 32'd0);
      step(1);
      chk("t5_c12_up", 32'(link_up), 32'd1);
      chk("t5_rxp", 32'(rx_hi - r0), 32'd0);
      chk("t5_allp", 32'(all_hi - a0), 32'd0);

      // 4: lock never comes: retries then escalation
      rst = 1'b1;
      rx_block_lock = 1'b0;
      step(2);
      rst = 1'b0;
      step(202);
      chk("t4_c202_state", 32'(link_state), 32'd1);
      chk("t4_c202_rxp", 32'(gt_reset_rx_datapath), 32'd0);
      step(1);
      chk("t4_c203_state", 32'(link_state), 32'd3);
      chk("t4_c203_rxp", 32'(gt_reset_rx_datapath), 32'd1);
      chk("t4_c203_retry", 32'(retry_count), 32'd1);
      step(205);
      chk("t4_c408_state", 32'(link_state), 32'd3);
      chk("t4_c408_rxp", 32'(gt_reset_rx_datapath), 32'd1);
      chk("t4_c408_retry", 32'(retry_count), 32'd2);
      step(204);
      chk("t4_c612_state", 32'(link_state), 32'd1);
      r0 = rx_hi;
      a0 = all_hi;
      step(1);
      chk("t4_c613_state", 32'(link_state), 32'd4);
      chk("t4_c613_allp", 32'(gt_reset_all), 32'd1);
      chk("t4_c613_rxp", 32'(gt_reset_rx_datapath), 32'd0);
      chk("t4_c613_retry", 32'(retry_count), 32'd0);
      step(7);
      chk("t4_allp_len", 32'(all_hi - a0), 32'd4);
      chk("t4_rxp_none", 32'(rx_hi - r0), 32'd0);
      chk("t4_c620_state", 32'(link_state), 32'd1);
      chk("t4_down", 32'(link_down_events), 32'd0);

      // 6: reset in the middle of an RX pulse
      step(198);
      chk("t6_c818_state", 32'(link_state), 32'd3);
      chk("t6_c818_retry", 32'(retry_count), 32'd1);
      step(1);
      chk("t6_c819_rxp", 32'(gt_reset_rx_datapath), 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_async_rxp", 32'(gt_reset_rx_datapath), 32'd0);
      chk("t6_async_state", 32'(link_state), 32'd0);
      chk("t6_async_retry", 32'(retry_count), 32'd0);
      step(2);
      rst = 1'b0;
      step(1);
      chk_idle("t6_post");

      chk("excl_pulses", 32'(both_hi), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
